// File: rtl/apb_mem_pkg.sv
// Shared types and helpers for the parametrised APB scratchpad memory.
package apb_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } apb_mem_state_t;

  localparam int WAIT_CNT_W = 4;

  function automatic int byte_lanes(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_WIDTH storage: asynchronous read port, synchronous byte-masked write port.
module apb_mem_array
  import apb_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64
) (
  input  logic                              clk,
  input  logic                              we,
  input  logic [byte_lanes(DATA_WIDTH)-1:0] wstrb,
  input  logic [$clog2(DEPTH)-1:0]          waddr,
  input  logic [DATA_WIDTH-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0]          raddr,
  output logic [DATA_WIDTH-1:0]             rdata
);

  localparam int LANES = byte_lanes(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[raddr];

  // Contents are deliberately left unreset; only strobed lanes are written.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (wstrb[i]) begin
          mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/apb_param_memory.sv
// APB slave scratchpad: three-state transfer FSM with wait states, byte strobes,
// error response on misaligned/out-of-range addresses and abort on Pselx drop.
module apb_param_memory
  import apb_mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                              Pclk,
  input  logic                              Prst,
  input  logic [ADDR_WIDTH-1:0]             Paddr,
  input  logic                              Pselx,
  input  logic                              Penable,
  input  logic                              Pwrite,
  input  logic [DATA_WIDTH-1:0]             Pwdata,
  input  logic [byte_lanes(DATA_WIDTH)-1:0] Pstrb,
  output logic                              Pready,
  output logic                              Pslverr,
  output logic [DATA_WIDTH-1:0]             Prdata
);

  localparam int LANES = byte_lanes(DATA_WIDTH);
  localparam int BL    = $clog2(LANES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(LANES - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);

  apb_mem_state_t          state, next_state;
  logic [WAIT_CNT_W-1:0]   cnt, cnt_next;
  logic [IDX_W-1:0]        idx_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [LANES-1:0]        strb_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   rd_q;

  logic [ADDR_WIDTH-1:0]   word_idx;
  logic                    misaligned;
  logic                    out_of_range;
  logic                    err;
  logic                    load;
  logic                    commit;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  // The lane mask is zero for byte-wide data, so misaligned collapses to 0 there.
  assign word_idx     = Paddr >> BL;
  assign misaligned   = (Paddr & LANE_MASK) != '0;
  assign out_of_range = word_idx >= DEPTH_A;
  assign err          = misaligned | out_of_range;

  apb_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk   (Pclk),
    .we    (commit),
    .wstrb (strb_q),
    .waddr (idx_q),
    .wdata (wdata_q),
    .raddr (word_idx[IDX_W-1:0]),
    .rdata (mem_rdata)
  );

  // Next-state and control decode.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    load       = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (Pselx && !Penable) begin
          load     = 1'b1;
          cnt_next = WAIT_LOAD;
          if (WAIT_STATES > 0) begin
            next_state = WAIT;
          end else begin
            next_state = DONE;
          end
        end else begin
          next_state = IDLE;
        end
      end
      WAIT: begin
        if (!Pselx) begin
          next_state = IDLE;
          cnt_next   = '0;
        end else if (cnt <= WAIT_CNT_W'(1)) begin
          next_state = DONE;
          cnt_next   = cnt - WAIT_CNT_W'(1);
        end else begin
          next_state = WAIT;
          cnt_next   = cnt - WAIT_CNT_W'(1);
        end
      end
      DONE: begin
        next_state = IDLE;
        commit     = Pselx & Penable & write_q & ~err_q;
      end
      default: begin
        next_state = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State, wait counter and setup-phase latches.
  always_ff @(posedge Pclk or posedge Prst) begin
    if (Prst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      err_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      if (load) begin
        idx_q   <= word_idx[IDX_W-1:0];
        write_q <= Pwrite;
        wdata_q <= Pwdata;
        strb_q  <= Pstrb;
        err_q   <= err;
        rd_q    <= err ? '0 : mem_rdata;
      end
    end
  end

  // Response outputs decode from state and latched flags only.
  always_comb begin
    Pready  = (state == DONE);
    Pslverr = (state == DONE) & err_q;
    if ((state == DONE) && !write_q && !err_q) begin
      Prdata = rd_q;
    end else begin
      Prdata = '0;
    end
  end

endmodule

// File: tb/tb_apb_param_memory.sv
// Scoreboard bench: two DUTs (0 and 3 wait states), randomized and directed
// transfers checked against a word-array reference model.
module tb_apb_param_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] paddr   [2];
  logic        psel    [2];
  logic        pen     [2];
  logic        pwr     [2];
  logic [31:0] pwdata  [2];
  logic [3:0]  pstrb   [2];
  logic        pready  [2];
  logic        pslverr [2];
  logic [31:0] prdata  [2];

  always #5 clk = ~clk;

  apb_param_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(64), .WAIT_STATES(0)) u_ws0 (
    .Pclk(clk), .Prst(rst), .Paddr(paddr[0]), .Pselx(psel[0]), .Penable(pen[0]),
    .Pwrite(pwr[0]), .Pwdata(pwdata[0]), .Pstrb(pstrb[0]),
    .Pready(pready[0]), .Pslverr(pslverr[0]), .Prdata(prdata[0]));

  apb_param_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(64), .WAIT_STATES(3)) u_ws3 (
    .Pclk(clk), .Prst(rst), .Paddr(paddr[1]), .Pselx(psel[1]), .Penable(pen[1]),
    .Pwrite(pwr[1]), .Pwdata(pwdata[1]), .Pstrb(pstrb[1]),
    .Pready(pready[1]), .Pslverr(pslverr[1]), .Prdata(prdata[1]));

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        err;
    int          rcyc;
    string       name;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model [2][64];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;

  function automatic int ws_of(input int inst);
    return (inst == 1) ? 3 : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every Pready cycle must match the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (pready[i]) begin
          if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_ready inst%0d: Pready=1, expected no response", i);
          end else begin
            e = q.pop_front();
            check({e.name, "_inst"}, 32'(i), 32'(e.inst));
            check({e.name, "_cycle"}, 32'(cyc), 32'(e.rcyc));
            check({e.name, "_slverr"}, {31'd0, pslverr[i]}, {31'd0, e.err});
            check({e.name, "_rdata"}, prdata[i], e.rdata);
          end
        end
      end
    end
  end

  // Issue the setup phase and push the model's expected response.
  task automatic setup(input int inst, input logic [31:0] addr, input logic wr,
                       input logic [31:0] data, input logic [3:0] strb,
                       input string name, input logic update);
    exp_t e;
    logic err;
    err     = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'd64);
    e.inst  = inst;
    e.err   = err;
    e.rcyc  = cyc + 1 + ws_of(inst);
    e.name  = name;
    e.rdata = (!wr && !err) ? model[inst][addr[7:2]] : 32'h0;
    if (wr && !err && update) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model[inst][addr[7:2]][b*8 +: 8] = data[b*8 +: 8];
      end
    end
    q.push_back(e);
    psel[inst]   = 1'b1;
    pen[inst]    = 1'b0;
    paddr[inst]  = addr;
    pwr[inst]    = wr;
    pwdata[inst] = data;
    pstrb[inst]  = strb;
  endtask

  // Bus fields are scrambled in the access phase; the DUT must use latched values.
  task automatic scramble(input int inst);
    pen[inst]    = 1'b1;
    paddr[inst]  = $urandom;
    pwdata[inst] = $urandom;
    pstrb[inst]  = 4'($urandom);
    pwr[inst]    = 1'($urandom_range(0, 1));
  endtask

  task automatic xfer(input int inst, input logic [31:0] addr, input logic wr,
                      input logic [31:0] data, input logic [3:0] strb, input string name);
    setup(inst, addr, wr, data, strb, name, 1'b1);
    @(posedge clk); #1;
    scramble(inst);
    for (int k = 0; k < 40 && !pready[inst]; k++) begin
      @(posedge clk); #1;
    end
    if (!pready[inst]) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: Pready=0 after 40 cycles, expected 1", name);
      void'(q.pop_back());
    end
    @(posedge clk); #1;
    psel[inst] = 1'b0;
    pen[inst]  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] old;
    int          inst;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      paddr[i] = 32'h0; psel[i] = 1'b0; pen[i] = 1'b0; pwr[i] = 1'b0;
      pwdata[i] = 32'h0; pstrb[i] = 4'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("reset_ready", {31'd0, pready[i]}, 32'h0);
      check("reset_slverr", {31'd0, pslverr[i]}, 32'h0);
      check("reset_rdata", prdata[i], 32'h0);
    end
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 64; w++) xfer(i, 32'(w * 4), 1'b1, $urandom, 4'hF, "init");

    for (int i = 0; i < 2; i++) begin
      xfer(i, 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, "wr_10");
      xfer(i, 32'h10, 1'b0, 32'h0, 4'h0, "rd_10");
      xfer(i, 32'h08, 1'b1, 32'h11223344, 4'hF, "wr_08");
      xfer(i, 32'h08, 1'b1, 32'hAABBCCDD, 4'h5, "wr_08_strb5");
      xfer(i, 32'h08, 0, 32'h0, 4'h0, "rd_08_strb");
      xfer(i, 32'h100, 1'b1, 32'h12345678, 4'hF, "wr_oor");
      xfer(i, 32'h102, 1'b0, 32'h0, 4'h0, "rd_misal_oor");
      xfer(i, 32'hFE, 1'b1, 32'hCAFEF00D, 4'hF, "wr_misal");
      xfer(i, 32'hFC, 1'b0, 32'h0, 4'h0, "rd_last");
      xfer(i, 32'h00, 1'b0, 32'h0, 4'h0, "rd_first");
      xfer(i, 32'h20, 1'b1, 32'h55AA55AA, 4'h0, "wr_strb0");
      xfer(i, 32'h20, 1'b0, 32'h0, 4'h0, "rd_strb0");
    end

    // Access phase without setup must be ignored.
    psel[0] = 1'b1; pen[0] = 1'b1; paddr[0] = 32'h10; pwr[0] = 1'b1;
    idle(3);
    psel[0] = 1'b0; pen[0] = 1'b0;
    xfer(0, 32'h10, 1'b0, 32'h0, 4'h0, "rd_after_noise");

    // Abort during WAIT on the 3-wait-state slave.
    old = model[1][6];
    setup(1, 32'h18, 1'b1, ~old, 4'hF, "abort_wait", 1'b0);
    void'(q.pop_back());
    @(posedge clk); #1;
    scramble(1);
    @(posedge clk); #1;
    psel[1] = 1'b0; pen[1] = 1'b0;
    idle(6);
    xfer(1, 32'h18, 1'b0, 32'h0, 4'h0, "rd_after_abort_wait");

    // Pselx dropped in DONE: Pready still shows, write is not committed.
    setup(0, 32'h1C, 1'b1, ~model[0][7], 4'hF, "abort_done", 1'b0);
    @(posedge clk); #1;
    psel[0] = 1'b0; pen[0] = 1'b0;
    idle(2);
    xfer(0, 32'h1C, 1'b0, 32'h0, 4'h0, "rd_after_abort_done");

    // Reset in the middle of a pending write.
    old = model[1][9];
    setup(1, 32'h24, 1'b1, ~old, 4'hF, "reset_mid", 1'b0);
    void'(q.pop_back());
    @(posedge clk); #1;
    scramble(1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_ready", {31'd0, pready[1]}, 32'h0);
    check("midrst_slverr", {31'd0, pslverr[1]}, 32'h0);
    check("midrst_rdata", prdata[1], 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; psel[1] = 1'b0; pen[1] = 1'b0;
    idle(1);
    xfer(1, 32'h24, 1'b0, 32'h0, 4'h0, "rd_after_reset");

    for (int n = 0; n < 300; n++) begin
      inst = $urandom_range(0, 1);
      a = 32'($urandom_range(0, 69) * 4);
      if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
      xfer(inst, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), "rand");
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
    end

    idle(5);
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_param_memory.md
# apb_param_memory

Parametrised APB slave memory, the successor of the team's fixed 32×32 APB memory slave. It adds configurable data width, depth and wait states, per-byte write strobes (Pstrb), and Pslverr reporting for out-of-range and misaligned accesses. It also adds abort handling when Pselx drops mid-transfer. It sits behind the APB bridge/decoder as a scratchpad or register-file target.

## Interface
- DATA_WIDTH, 32: Pwdata/Prdata width; must be 8, 16, 32 or 64.
- ADDR_WIDTH, 32: Paddr width (byte address).
- DEPTH, 64: number of DATA_WIDTH-bit words; power of two, ≥ 2.
- WAIT_STATES, 0: Pready-low cycles inserted in every access phase; range 0–15.

- Pclk  in  1  clock; all logic on rising edge.
- Prst  in  1  reset; asynchronous, active-high.
- Paddr  in  ADDR_WIDTH  byte address.
- Pselx  in  1  slave select.
- Penable  in  1  access-phase flag.
- Pwrite  in  1  1 = write, 0 = read.
- Pwdata  in  DATA_WIDTH  write data.
- Pstrb  in  DATA_WIDTH/8  byte-lane write enables.
- Pready  out  1  transfer complete.
- Pslverr  out  1  error response; valid only while Pready=1.
- Prdata  out  DATA_WIDTH  read data; valid only while Pready=1.

## Operation
- Definitions:
  - BL = log2(DATA_WIDTH/8).
  - Word index = Paddr >> BL.
  - misaligned = Paddr[BL-1:0] ≠ 0. When BL = 0, misaligned is always 0.
  - out_of_range = word index ≥ DEPTH.
  - err = misaligned | out_of_range.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: on Pselx=1 & Penable=0 (setup phase):
    - Latch Paddr, Pwrite, Pwdata, Pstrb and err.
    - Load the read register with the memory word at the word index, or 0 if err.
    - Load the wait counter with WAIT_STATES.
    - Go to WAIT if WAIT_STATES > 0, otherwise DONE.
  - IDLE: Penable=1 without a preceding setup is ignored; the FSM stays in IDLE.
  - WAIT: counter decrements each cycle; go to DONE when it reaches 1.
  - DONE: Pready=1. On the closing edge:
    - If write & !err & Penable, commit each byte lane i where Pstrb[i]=1.
    - Always return to IDLE.
- Abort: Pselx=0 in WAIT or DONE → IDLE next edge, no memory write, no error.
- Back-to-back: the next setup phase is the cycle after DONE, so it is sampled in IDLE. There is no dead cycle beyond the APB protocol minimum.
- Latched fields are used throughout the transfer. Changes on the bus after setup are ignored.
- Error write: memory unchanged, Pslverr=1. Error read: Prdata=0, Pslverr=1.
- Pstrb=0 on a write is legal and changes nothing, Pslverr=0.
- Memory contents are not reset.

## Timing
- Reset values: Pready=0, Pslverr=0, Prdata=0, FSM=IDLE, wait counter=0.
- Reset mid-transfer drops the transfer immediately and blocks the pending write.
- Output decode is combinational from state only:
  - Pready = (state==DONE).
  - Pslverr = DONE & err_q.
  - Prdata = read register when DONE & !Pwrite_q & !err_q, else 0.
- Latency: setup at cycle T gives Pready=1 in cycle T+1+WAIT_STATES.
- Write data is visible to a read whose setup is in cycle T+2+WAIT_STATES or later, which is the earliest legal back-to-back setup.
- Throughput: one transfer per 2+WAIT_STATES cycles.

## Structure
- Package apb_mem_pkg:
  - State enum apb_mem_state_t {IDLE, WAIT, DONE}.
  - Helper function byte_lanes(DATA_WIDTH).
  - Constant WAIT_CNT_W = 4.
- Sub-module apb_mem_array: DEPTH×DATA_WIDTH array with:
  - One asynchronous read port.
  - One synchronous write port with per-byte enables.
- The top level holds the FSM, latches, error decode and output muxing.

## Test plan
- Reset: Prst=1 mid-WAIT, WAIT_STATES=3, write pending → Pready/Pslverr/Prdata=0; the pending write is blocked, so a later read of that address does not return the pending write's data.
- Zero-wait write/read, DATA_WIDTH=32: write 0xDEADBEEF to 0x10, strobe 0xF; read 0x10 → Pready in second cycle of each, Prdata=0xDEADBEEF, Pslverr=0.
- Byte strobes: word 0x8 preloaded 0x11223344; write 0xAABBCCDD, strobe 0x5 → read returns 0x11BB33DD.
- Errors, DEPTH=64: write to 0x100 and read from 0x102 → Pslverr=1 with Pready=1; Prdata=0 on the read; memory unchanged.
- Wait states, WAIT_STATES=3: setup at cycle T → Pready low in T+1..T+3, high in T+4; back-to-back transfers with no idle cycle between them both complete.
- Abort: Pselx dropped in a WAIT cycle of a write → no Pready, the FSM returns to IDLE, and the word is unchanged on readback.
